// File: rtl/rom_arb_pkg.sv
// Shared core definitions for the instruction/data ROM port arbiter.
// Owner encoding and the starvation limit default.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/rom_arb_starve.sv
// Fetch starvation counter: counts consecutive denied fetch cycles.
// Saturates at STARVE_MAX; starve flags the forced-fetch cycle.
module rom_arb_starve
    import rom_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic starve
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt != MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign starve = (cnt == MAX);

endmodule

// File: rtl/rom_arb.sv
// Single-port ROM arbiter between fetch and load requesters.
// Load wins by default; a starved fetch is forced through.
module rom_arb
    import rom_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_kill_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_gnt_o,
    output logic        ld_rvalid_o,
    output logic [31:0] ld_rdata_o,
    output logic        rom_en_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i
);

    owner_e owner;
    logic   starve;
    logic   if_sel;
    logic   ld_sel;

    rom_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .req    (if_req_i),
        .gnt    (if_gnt_o),
        .starve (starve)
    );

    assign if_sel = !rst && if_req_i && (starve || !ld_req_i);
    assign ld_sel = !rst && ld_req_i && !if_sel;

    always_comb begin
        if_gnt_o   = 1'b0;
        ld_gnt_o   = 1'b0;
        rom_addr_o = '0;
        unique case (1'b1)
            if_sel: begin
                if_gnt_o   = 1'b1;
                rom_addr_o = if_addr_i;
            end
            ld_sel: begin
                ld_gnt_o   = 1'b1;
                rom_addr_o = ld_addr_i;
            end
            default: ;
        endcase
    end

    assign rom_en_o = if_gnt_o | ld_gnt_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else if (if_gnt_o) begin
            owner <= OWN_IF;
        end else if (ld_gnt_o) begin
            owner <= OWN_LD;
        end else begin
            owner <= OWN_NONE;
        end
    end

    // A kill only drops the fetch response; the ROM read itself is wasted.
    assign if_rvalid_o = !rst && (owner == OWN_IF) && !if_kill_i;
    assign ld_rvalid_o = !rst && (owner == OWN_LD);
    assign if_rdata_o  = if_rvalid_o ? rom_data_i : '0;
    assign ld_rdata_o  = ld_rvalid_o ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_arb.sv
// Directed and random checks for the fetch/load ROM arbiter.
// ROM model returns a fixed pattern of the address one cycle after enable.
module tb_rom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_kill_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ld_req_i;
    logic [31:0] ld_addr_i;
    logic        ld_gnt_o;
    logic        ld_rvalid_o;
    logic [31:0] ld_rdata_o;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;

    logic [31:0] gnts;
    logic [31:0] rvs;

    int checks = 0;
    int errors = 0;

    rom_arb #(
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_kill_i   (if_kill_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ld_req_i    (ld_req_i),
        .ld_addr_i   (ld_addr_i),
        .ld_gnt_o    (ld_gnt_o),
        .ld_rvalid_o (ld_rvalid_o),
        .ld_rdata_o  (ld_rdata_o),
        .rom_en_o    (rom_en_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i)
    );

    always #5 clk = ~clk;

    assign gnts = {30'b0, if_gnt_o, ld_gnt_o};
    assign rvs  = {30'b0, if_rvalid_o, ld_rvalid_o};

    function automatic logic [31:0] romf(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk)
        rom_data_i <= rom_en_o ? romf(rom_addr_o) : 32'h5a5a5a5a;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(logic r, logic ir, logic [31:0] ia, logic k,
                         logic lr, logic [31:0] la);
        @(negedge clk);
        rst       = r;
        if_req_i  = ir;
        if_addr_i = ia;
        if_kill_i = k;
        ld_req_i  = lr;
        ld_addr_i = la;
        #1;
    endtask

    logic [31:0] st_exp [6];

    initial begin
        logic        ir, lr, k;
        logic [31:0] ia, la;
        logic        e_if, e_ld, p_if, p_ld;
        logic [31:0] e_addr, p_addr;
        int          mcnt;

        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0; if_kill_i = 1'b0;
        ld_req_i = 1'b0; ld_addr_i = '0;

        // reset with requests active
        drive(1, 1, 32'h100, 0, 1, 32'h400);
        chk("rst_gnt", gnts, 32'd0);
        chk("rst_en", {31'b0, rom_en_o}, 32'd0);
        chk("rst_addr", rom_addr_o, 32'd0);
        drive(1, 1, 32'h100, 1, 1, 32'h400);
        chk("rst_rv", rvs, 32'd0);
        chk("rst_rdata", if_rdata_o | ld_rdata_o, 32'd0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("post_rst_rv", rvs, 32'd0);

        // single fetch
        drive(0, 1, 32'h100, 0, 0, 32'h0);
        chk("sf_gnt", gnts, 32'd2);
        chk("sf_addr", rom_addr_o, 32'h100);
        chk("sf_en", {31'b0, rom_en_o}, 32'd1);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("sf_rv", rvs, 32'd2);
        chk("sf_data", if_rdata_o, romf(32'h100));
        chk("sf_ld_rdata", ld_rdata_o, 32'd0);
        chk("idle_en", {31'b0, rom_en_o}, 32'd0);
        chk("idle_addr", rom_addr_o, 32'd0);

        // contention: load first, fetch when load drops
        drive(0, 1, 32'h0, 0, 1, 32'h400);
        chk("ct0_gnt", gnts, 32'd1);
        chk("ct0_addr", rom_addr_o, 32'h400);
        drive(0, 1, 32'h0, 0, 1, 32'h404);
        chk("ct1_gnt", gnts, 32'd1);
        chk("ct1_addr", rom_addr_o, 32'h404);
        chk("ct1_rv", rvs, 32'd1);
        chk("ct1_data", ld_rdata_o, romf(32'h400));
        drive(0, 1, 32'h0, 0, 0, 32'h0);
        chk("ct2_gnt", gnts, 32'd2);
        chk("ct2_addr", rom_addr_o, 32'h0);
        chk("ct2_rv", rvs, 32'd1);
        chk("ct2_data", ld_rdata_o, romf(32'h404));
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("ct3_rv", rvs, 32'd2);
        chk("ct3_data", if_rdata_o, romf(32'h0));

        // starvation: ld x4, if, ld
        st_exp = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd1};
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 32'h80, 0, 1, 32'h600 + 32'(i * 4));
            chk($sformatf("st%0d_gnt", i), gnts, st_exp[i]);
            if (i > 0)
                chk($sformatf("st%0d_rv", i), rvs, st_exp[i-1]);
        end
        chk("st4_addr_seen", {31'b0, if_gnt_o}, 32'd0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("st_last_rv", rvs, 32'd1);
        chk("st_last_data", ld_rdata_o, romf(32'h614));

        // kill
        drive(0, 1, 32'h200, 0, 0, 32'h0);
        chk("kl0_gnt", gnts, 32'd2);
        drive(0, 1, 32'h204, 1, 0, 32'h0);
        chk("kl1_gnt", gnts, 32'd2);
        chk("kl1_addr", rom_addr_o, 32'h204);
        chk("kl1_rv", rvs, 32'd0);
        chk("kl1_rdata", if_rdata_o, 32'd0);
        drive(0, 0, 32'h0, 0, 1, 32'h500);
        chk("kl2_rv", rvs, 32'd2);
        chk("kl2_data", if_rdata_o, romf(32'h204));
        chk("kl2_gnt", gnts, 32'd1);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("kl3_rv", rvs, 32'd1);
        chk("kl3_data", ld_rdata_o, romf(32'h500));

        // reset mid-stream
        drive(0, 0, 32'h0, 0, 1, 32'h300);
        chk("rs0_gnt", gnts, 32'd1);
        drive(1, 1, 32'h100, 0, 1, 32'h300);
        chk("rs1_gnt", gnts, 32'd0);
        chk("rs1_rv", rvs, 32'd0);
        chk("rs1_en", {31'b0, rom_en_o}, 32'd0);
        chk("rs1_addr", rom_addr_o, 32'd0);
        chk("rs1_rdata", if_rdata_o | ld_rdata_o, 32'd0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("rs2_rv", rvs, 32'd0);

        // random traffic against a reference model
        mcnt = 0;
        p_if = 1'b0;
        p_ld = 1'b0;
        p_addr = '0;
        for (int n = 0; n < 10000; n++) begin
            ir = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 3) != 0);
            k  = 1'($urandom_range(0, 4) == 0);
            ia = $urandom() & 32'h0000fffc;
            la = $urandom() & 32'h0000fffc;
            drive(0, ir, ia, k, lr, la);
            e_if   = ir && (mcnt == 4 || !lr);
            e_ld   = lr && !e_if;
            e_addr = e_if ? ia : (e_ld ? la : 32'h0);
            chk("rnd_gnt", gnts, {30'b0, e_if, e_ld});
            chk("rnd_addr", rom_addr_o, e_addr);
            chk("rnd_rv", rvs, {30'b0, p_if && !k, p_ld});
            chk("rnd_data", if_rdata_o | ld_rdata_o,
                ((p_if && !k) || p_ld) ? romf(p_addr) : 32'h0);
            if (!ir || e_if)
                mcnt = 0;
            else if (mcnt != 4)
                mcnt++;
            p_if   = e_if;
            p_ld   = e_ld;
            p_addr = e_addr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
